// File: rtl/inactivity_watchdog_if.sv
// Signal bundle between the inactivity watchdog, the session controller and
// the upstream 1 ms timer; the slave modport is the watchdog's view.
interface inactivity_watchdog_if;
  logic       arm;
  logic       kick;
  logic       tick_1ms;
  logic       timer_en;
  logic       warn;
  logic       expire;
  logic [7:0] remaining;
  logic [9:0] ms_count;

  modport master (
    output arm, kick, tick_1ms,
    input  timer_en, warn, expire, remaining, ms_count
  );

  modport slave (
    input  arm, kick, tick_1ms,
    output timer_en, warn, expire, remaining, ms_count
  );
endinterface

// File: rtl/inactivity_watchdog.sv
// Session inactivity watchdog: folds 1 ms timer pulses into seconds, counts down
// the inactivity window, warns near the end and pulses expire once on timeout.
module inactivity_watchdog #(
  parameter int MS_PER_SEC  = 1000,
  parameter int TIMEOUT_SEC = 15,
  parameter int WARN_SEC    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  inactivity_watchdog_if.slave  bus
);

  localparam logic [9:0] MS_LAST  = 10'(MS_PER_SEC - 1);
  localparam logic [7:0] TIMEOUT  = 8'(TIMEOUT_SEC);
  localparam logic [7:0] WARN_LIM = 8'(WARN_SEC);

  typedef enum logic [1:0] {IDLE, RUN, WARN, EXPIRED} state_t;

  state_t     r_state, w_state_next;
  logic       r_tick_q;
  logic       r_timer_en, w_timer_en_next;
  logic       r_warn, w_warn_next;
  logic       r_expire, w_expire_next;
  logic [7:0] r_remaining, w_remaining_next;
  logic [9:0] r_ms_count, w_ms_count_next;
  logic       w_tick_edge;
  logic [7:0] w_rem_dec;

  // A stuck-high TimeOut must count only once, so only rising edges advance.
  assign w_tick_edge = bus.tick_1ms & ~r_tick_q;
  assign w_rem_dec   = r_remaining - 8'd1;

  always_comb begin
    w_state_next     = r_state;
    w_timer_en_next  = r_timer_en;
    w_warn_next      = r_warn;
    w_expire_next    = 1'b0;
    w_remaining_next = r_remaining;
    w_ms_count_next  = r_ms_count;
    case (r_state)
      IDLE: begin
        w_remaining_next = TIMEOUT;
        w_ms_count_next  = '0;
        w_warn_next      = 1'b0;
        w_timer_en_next  = 1'b0;
        if (bus.arm) begin
          w_state_next    = RUN;
          w_timer_en_next = 1'b1;
        end
      end
      RUN, WARN: begin
        w_timer_en_next = 1'b1;
        if (!bus.arm) begin
          w_state_next     = IDLE;
          w_remaining_next = TIMEOUT;
          w_ms_count_next  = '0;
          w_timer_en_next  = 1'b0;
          w_warn_next      = 1'b0;
        end else if (bus.kick) begin
          // Dropping the enable for one cycle restarts the upstream ms counter.
          w_state_next     = RUN;
          w_remaining_next = TIMEOUT;
          w_ms_count_next  = '0;
          w_timer_en_next  = 1'b0;
          w_warn_next      = 1'b0;
        end else if (w_tick_edge) begin
          if (r_ms_count < MS_LAST) begin
            w_ms_count_next = r_ms_count + 10'd1;
          end else begin
            w_ms_count_next = '0;
            if (r_remaining != 8'd0) begin
              w_remaining_next = w_rem_dec;
              if (w_rem_dec == 8'd0) begin
                w_state_next    = EXPIRED;
                w_expire_next   = 1'b1;
                w_timer_en_next = 1'b0;
                w_warn_next     = 1'b0;
              end else if (w_rem_dec <= WARN_LIM) begin
                w_state_next = WARN;
                w_warn_next  = 1'b1;
              end
            end
          end
        end
      end
      EXPIRED: begin
        w_timer_en_next  = 1'b0;
        w_warn_next      = 1'b0;
        w_remaining_next = '0;
        w_ms_count_next  = '0;
        if (!bus.arm) begin
          w_state_next     = IDLE;
          w_remaining_next = TIMEOUT;
        end
      end
      default: begin
        w_state_next     = IDLE;
        w_remaining_next = TIMEOUT;
        w_ms_count_next  = '0;
        w_timer_en_next  = 1'b0;
        w_warn_next      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tick_q    <= 1'b0;
      r_timer_en  <= 1'b0;
      r_warn      <= 1'b0;
      r_expire    <= 1'b0;
      r_remaining <= TIMEOUT;
      r_ms_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_tick_q    <= bus.tick_1ms;
      r_timer_en  <= w_timer_en_next;
      r_warn      <= w_warn_next;
      r_expire    <= w_expire_next;
      r_remaining <= w_remaining_next;
      r_ms_count  <= w_ms_count_next;
    end
  end

  assign bus.timer_en  = r_timer_en;
  assign bus.warn      = r_warn;
  assign bus.expire    = r_expire;
  assign bus.remaining = r_remaining;
  assign bus.ms_count  = r_ms_count;

endmodule
